// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit: one of eight ops on two WIDTH-bit operands, registered result
// buffered in a 2-entry skid behind valid/ready, with zero/parity flags and a delivery count.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero,
  output logic             y_parity,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_y;
  logic             r_zero;
  logic             r_parity;
  logic [WIDTH-1:0] r_skid;
  logic [CNT_W-1:0] r_count;

  logic [WIDTH-1:0] w_res;
  logic             w_acc;
  logic             w_dlv;

  assign w_acc = in_valid & r_in_ready;
  assign w_dlv = r_out_valid & out_ready;

  always_comb begin
    w_res = '0;
    case (op)
      3'd0:    w_res = a & b;
      3'd1:    w_res = a | b;
      3'd2:    w_res = a ^ b;
      3'd3:    w_res = ~(a & b);
      3'd4:    w_res = ~(a | b);
      3'd5:    w_res = ~(a ^ b);
      3'd6:    w_res = ~a;
      default: w_res = a;
    endcase
  end

  // Flags are recomputed whenever OUT is loaded so they always track the y on the port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StEmpty;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_zero      <= 1'b1;
      r_parity    <= 1'b0;
      r_skid      <= '0;
      r_count     <= '0;
    end else begin
      if (w_dlv) begin
        r_count <= r_count + CNT_W'(1);
      end
      case (r_state)
        StEmpty: begin
          r_in_ready <= 1'b1;
          if (w_acc) begin
            r_y         <= w_res;
            r_zero      <= (w_res == '0);
            r_parity    <= ^w_res;
            r_out_valid <= 1'b1;
            r_state     <= StOne;
          end
        end
        StOne: begin
          if (w_acc && w_dlv) begin
            r_y      <= w_res;
            r_zero   <= (w_res == '0);
            r_parity <= ^w_res;
          end else if (w_acc) begin
            r_skid     <= w_res;
            r_in_ready <= 1'b0;
            r_state    <= StTwo;
          end else if (w_dlv) begin
            r_out_valid <= 1'b0;
            r_state     <= StEmpty;
          end
        end
        StTwo: begin
          if (w_dlv) begin
            r_y        <= r_skid;
            r_zero     <= (r_skid == '0);
            r_parity   <= ^r_skid;
            r_in_ready <= 1'b1;
            r_state    <= StOne;
          end
        end
        default: begin
          r_state     <= StEmpty;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign y_zero    = r_zero;
  assign y_parity  = r_parity;
  assign op_count  = r_count;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: stimulus pushes expected results, a negedge
// monitor pops and compares whatever the DUT delivers.
module tb_logic_unit_pipe;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             z;
    logic             p;
  } res_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             y_zero;
  logic             y_parity;
  logic [CNT_W-1:0] op_count;

  logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .y_zero    (y_zero),
    .y_parity  (y_parity),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_fail = 0;
  res_t sb[$];
  res_t dlv_log[$];
  int   model_cnt = 0;
  int   edges = 0;
  int   n_acc = 0;
  int   n_dlv = 0;
  int   n_nrdy = 0;
  logic acc_last = 1'b0;
  logic prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_y = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: bit-by-bit truth of each op, flags from a ones count.
  function automatic res_t ref_model(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                                     input logic [2:0] rop);
    res_t r;
    int   ones = 0;
    for (int i = 0; i < WIDTH; i++) begin
      logic x, yb, o;
      x  = ra[i];
      yb = rb[i];
      case (rop)
        3'd0:    o = x && yb;
        3'd1:    o = x || yb;
        3'd2:    o = (x != yb);
        3'd3:    o = !(x && yb);
        3'd4:    o = !(x || yb);
        3'd5:    o = (x == yb);
        3'd6:    o = !x;
        default: o = x;
      endcase
      r.y[i] = o;
      if (o) ones++;
    end
    r.z = (ones == 0);
    r.p = (ones % 2 == 1);
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else if (edges < 2) edges <= edges + 1;
  end

  // Monitor: inputs and outputs are stable here, commit happens at the next posedge.
  always @(negedge clk) begin
    if (!rst) begin
      logic acc, dlv;
      check("out_valid", 32'(out_valid), 32'(sb.size() > 0));
      check("in_ready", 32'(in_ready), 32'((edges > 0) && (sb.size() < 2)));
      check("op_count", 32'(op_count), 32'(model_cnt));
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_y", 32'(y), 32'(prev_y));
      end
      if (out_valid && sb.size() > 0) begin
        check("y", 32'(y), 32'(sb[0].y));
        check("y_zero", 32'(y_zero), 32'(sb[0].z));
        check("y_parity", 32'(y_parity), 32'(sb[0].p));
      end
      dlv = out_valid & out_ready;
      acc = in_valid & in_ready;
      if (dlv) begin
        dlv_log.push_back({y, y_zero, y_parity});
        if (sb.size() > 0) void'(sb.pop_front());
        model_cnt = (model_cnt + 1) % (1 << CNT_W);
        n_dlv++;
      end
      if (acc) begin
        sb.push_back(ref_model(a, b, op));
        n_acc++;
      end
      if (!in_ready) n_nrdy++;
      acc_last   = acc;
      prev_stall = out_valid & ~out_ready;
      prev_y     = y;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                      input logic [2:0] top);
    logic ok = 1'b0;
    a = ta; b = tb; op = top; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (acc_last) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_timeout", 32'(ok), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    logic ok = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (sb.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_timeout", 32'(ok), 32'd1);
  endtask

  // Random traffic; the source holds its transaction until accepted.
  task automatic run(input int n, input int pv, input int pr);
    for (int i = 0; i < n; i++) begin
      if (!in_valid || acc_last) begin
        in_valid = ($urandom_range(99) < pv);
        a  = WIDTH'($urandom);
        b  = WIDTH'($urandom);
        op = 3'($urandom_range(7));
      end
      out_ready = ($urandom_range(99) < pr);
      cyc();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] tbl_y[8];
    logic             tbl_z[8];
    logic [CNT_W-1:0] wrap_exp[3];
    int               acc0;
    int               dlv0;
    int               nrdy0;
    tbl_y = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h3A, 8'hC5};
    tbl_z = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    wrap_exp = '{4'd15, 4'd0, 4'd1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    #1;
    check("rst_y_zero", 32'(y_zero), 32'd1);
    check("rst_y", 32'(y), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rel_in_ready0", 32'(in_ready), 32'd0);
    cyc();
    check("rel_in_ready1", 32'(in_ready), 32'd1);

    // Counter wrap with CNT_W=4.
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      send(WIDTH'($urandom), WIDTH'($urandom), 3'($urandom_range(7)));
      cyc();
      if (i >= 14) check("wrap_count", 32'(op_count), 32'(wrap_exp[i-14]));
    end
    drain();

    // All ops on fixed operands.
    dlv_log.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(8'hC5, 8'h3A, 3'(i));
    drain();
    check("ops_count", 32'(dlv_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < dlv_log.size(); i++) begin
      check("ops_y", 32'(dlv_log[i].y), 32'(tbl_y[i]));
      check("ops_zero", 32'(dlv_log[i].z), 32'(tbl_z[i]));
      check("ops_parity", 32'(dlv_log[i].p), 32'd0);
    end

    // Backpressure: two fit, third waits.
    dlv_log.delete();
    out_ready = 1'b0;
    acc0 = n_acc;
    send(8'h12, 8'h34, 3'd0);
    send(8'h56, 8'h78, 3'd1);
    a = 8'h9A; b = 8'hBC; op = 3'd2; in_valid = 1'b1;
    repeat (3) cyc();
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_accepted", 32'(n_acc - acc0), 32'd2);
    out_ready = 1'b1;
    cyc();
    check("bp_ready_back", 32'(in_ready), 32'd1);
    for (int i = 0; i < 10 && !acc_last; i++) cyc();
    in_valid = 1'b0;
    drain();
    check("bp_delivered", 32'(dlv_log.size()), 32'd3);

    // Streaming at full rate.
    acc0 = n_acc; dlv0 = n_dlv; nrdy0 = n_nrdy;
    in_valid = 1'b0;
    run(100, 100, 100);
    check("stream_acc", 32'(n_acc - acc0), 32'd100);
    check("stream_nrdy", 32'(n_nrdy - nrdy0), 32'd0);
    in_valid = 1'b0;
    cyc();
    check("stream_dlv", 32'(n_dlv - dlv0), 32'd100);
    drain();

    // Reset mid-stream with both entries full.
    out_ready = 1'b0;
    send(8'hF0, 8'h0F, 3'd1);
    send(8'hAA, 8'h55, 3'd2);
    cyc();
    check("full_in_ready", 32'(in_ready), 32'd0);
    #2 rst = 1'b1;
    sb.delete(); model_cnt = 0; prev_stall = 1'b0; acc_last = 1'b0; in_valid = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_op_count", 32'(op_count), 32'd0);
    check("mid_rst_y_zero", 32'(y_zero), 32'd1);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rel_in_ready0", 32'(in_ready), 32'd0);
    cyc();
    check("mid_rel_in_ready1", 32'(in_ready), 32'd1);

    // Random valid/ready.
    run(10000, 50, 50);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
